// File: rtl/paged_avmm_window_if.sv
// Avalon-MM bus bundle for the paged window responder: 32-bit control slave
// plus the DW-wide paged window slave.
interface paged_avmm_window_if #(
  parameter int unsigned DW = 64,
  parameter int unsigned WA = 4
);
  localparam int unsigned BEW = DW / 8;

  logic [3:0]     ctl_address;
  logic           ctl_read;
  logic           ctl_write;
  logic [31:0]    ctl_writedata;
  logic [31:0]    ctl_readdata;
  logic           ctl_readdatavalid;

  logic [WA-1:0]  win_address;
  logic           win_read;
  logic           win_write;
  logic [DW-1:0]  win_writedata;
  logic [BEW-1:0] win_byteenable;
  logic [DW-1:0]  win_readdata;
  logic           win_readdatavalid;

  modport master (
    output ctl_address, ctl_read, ctl_write, ctl_writedata,
    input  ctl_readdata, ctl_readdatavalid,
    output win_address, win_read, win_write, win_writedata, win_byteenable,
    input  win_readdata, win_readdatavalid
  );

  modport slave (
    input  ctl_address, ctl_read, ctl_write, ctl_writedata,
    output ctl_readdata, ctl_readdatavalid,
    input  win_address, win_read, win_write, win_writedata, win_byteenable,
    output win_readdata, win_readdatavalid
  );
endinterface

// File: rtl/paged_avmm_window.sv
// Paged Avalon-MM window: control slave selects a page, window slave accesses
// that page of a PAGE_COUNT*PAGE_BYTES backing memory with 2-cycle reads.
module paged_avmm_window #(
  parameter int unsigned DW         = 64,
  parameter int unsigned PAGE_BYTES = 128,
  parameter int unsigned PAGE_COUNT = 4,
  parameter int unsigned WA         = 4
) (
  input  logic                clk_in,
  input  logic                rstn,
  paged_avmm_window_if.slave  bus,
  output logic [7:0]          page_sel
);

  localparam int unsigned BEW       = DW / 8;
  localparam int unsigned WORDS     = PAGE_BYTES * 8 / DW;
  localparam int unsigned PW        = (PAGE_COUNT > 1) ? $clog2(PAGE_COUNT) : 1;
  localparam int unsigned MAW       = PW + WA;
  localparam int unsigned MEM_DEPTH = PAGE_COUNT * WORDS;

  localparam logic [31:0]   ID_VALUE = 32'h5041_4745;
  localparam logic [DW-1:0] OOB_DATA = {(DW / 32){32'hDEAD_BEEF}};

  localparam logic [3:0] A_ID   = 4'h0;
  localparam logic [3:0] A_PCNT = 4'h1;
  localparam logic [3:0] A_PSEL = 4'h4;
  localparam logic [3:0] A_STAT = 4'h5;
  localparam logic [3:0] A_WCNT = 4'h6;
  localparam logic [3:0] A_RCNT = 4'h7;

  // Control-side state
  logic [7:0]  page_sel_q, page_sel_d;
  logic        err_q, err_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] ctl_rdata_q, ctl_rdata_d;
  logic        ctl_rvalid_q, ctl_rvalid_d;

  // Window read pipeline
  logic           s1_valid_q, s1_valid_d;
  logic           s1_oob_q, s1_oob_d;
  logic [MAW-1:0] s1_addr_q, s1_addr_d;
  logic           s2_valid_q, s2_valid_d;
  logic [DW-1:0]  s2_data_q, s2_data_d;

  logic [DW-1:0]  mem_q [MEM_DEPTH];

  logic           ctl_wr_c;
  logic           ctl_rd_c;
  logic           win_wr_c;
  logic           win_rd_c;
  logic           win_oob_c;
  logic [MAW-1:0] win_maddr_c;
  logic [DW-1:0]  mem_rdata_c;
  logic           unused_ctl_wdata_c;

  // A write wins over a simultaneous read on the same slave
  assign ctl_wr_c    = bus.ctl_write;
  assign ctl_rd_c    = bus.ctl_read & ~bus.ctl_write;
  assign win_wr_c    = bus.win_write;
  assign win_rd_c    = bus.win_read & ~bus.win_write;
  assign win_oob_c   = (32'(page_sel_q) >= PAGE_COUNT);
  assign win_maddr_c = {page_sel_q[PW-1:0], bus.win_address};
  assign mem_rdata_c = mem_q[s1_addr_q];

  assign unused_ctl_wdata_c = ^bus.ctl_writedata[31:8];

  // Control register next-state and read mux
  always_comb begin
    page_sel_d   = page_sel_q;
    err_d        = err_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    ctl_rvalid_d = ctl_rd_c;
    ctl_rdata_d  = '0;

    if (ctl_wr_c && (bus.ctl_address == A_PSEL)) begin
      page_sel_d = bus.ctl_writedata[7:0];
    end
    if (ctl_wr_c && (bus.ctl_address == A_STAT) && bus.ctl_writedata[0]) begin
      err_d = 1'b0;
    end
    // Set is evaluated after clear so a coincident set wins
    if ((win_wr_c || win_rd_c) && win_oob_c) begin
      err_d = 1'b1;
    end
    if (win_wr_c) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
    if (win_rd_c) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end

    if (ctl_rd_c) begin
      case (bus.ctl_address)
        A_ID:    ctl_rdata_d = ID_VALUE;
        A_PCNT:  ctl_rdata_d = 32'(PAGE_COUNT);
        A_PSEL:  ctl_rdata_d = {24'h0, page_sel_q};
        A_STAT:  ctl_rdata_d = {31'h0, err_q};
        A_WCNT:  ctl_rdata_d = wr_cnt_q;
        A_RCNT:  ctl_rdata_d = rd_cnt_q;
        default: ctl_rdata_d = '0;
      endcase
    end
  end

  // Window read pipeline next-state; page is latched with the command
  always_comb begin
    s1_valid_d = win_rd_c;
    s1_oob_d   = win_oob_c;
    s1_addr_d  = win_maddr_c;
    s2_valid_d = s1_valid_q;
    s2_data_d  = '0;
    if (s1_valid_q) begin
      s2_data_d = s1_oob_q ? OOB_DATA : mem_rdata_c;
    end
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      page_sel_q   <= '0;
      err_q        <= 1'b0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      ctl_rdata_q  <= '0;
      ctl_rvalid_q <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_oob_q     <= 1'b0;
      s1_addr_q    <= '0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
    end else begin
      page_sel_q   <= page_sel_d;
      err_q        <= err_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      ctl_rdata_q  <= ctl_rdata_d;
      ctl_rvalid_q <= ctl_rvalid_d;
      s1_valid_q   <= s1_valid_d;
      s1_oob_q     <= s1_oob_d;
      s1_addr_q    <= s1_addr_d;
      s2_valid_q   <= s2_valid_d;
      s2_data_q    <= s2_data_d;
    end
  end

  // Backing memory: byte-enabled write in the acceptance cycle, never reset
  always_ff @(posedge clk_in) begin
    if (win_wr_c && !win_oob_c) begin
      for (int b = 0; b < int'(BEW); b++) begin
        if (bus.win_byteenable[b]) begin
          mem_q[win_maddr_c][8*b +: 8] <= bus.win_writedata[8*b +: 8];
        end
      end
    end
  end

  assign bus.ctl_readdata      = ctl_rdata_q;
  assign bus.ctl_readdatavalid = ctl_rvalid_q;
  assign bus.win_readdata      = s2_data_q;
  assign bus.win_readdatavalid = s2_valid_q;
  assign page_sel              = page_sel_q;

endmodule
